// File: rtl/seq_det_stream_ctrl_pkg.sv
// Shared types and defaults for the sequence-detector stream controller.
// Imported by the controller, its hit counter and the bench.
package seq_det_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_SHIFT = 2'b10
  } state_t;

  localparam int unsigned DEF_W    = 8;
  localparam int unsigned DEF_CW   = 8;
  localparam logic        DEF_FILL = 1'b1;

endpackage

// File: rtl/seq_det_stream_ctrl_if.sv
// Word-wide valid/ready stream feeding the controller.
// The source uses the master modport and the controller uses the slave modport.
interface seq_det_stream_ctrl_if #(
  parameter int unsigned W = seq_det_stream_ctrl_pkg::DEF_W
) ();

  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/seq_det_stream_ctrl_hit_counter.sv
// Counts detector hits: registered hit pulse, saturating count with clear
// priority, and a sticky threshold interrupt.
module seq_det_hit_counter
  import seq_det_stream_ctrl_pkg::*;
#(
  parameter int unsigned CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hit,
  input  logic          clr_cnt,
  input  logic          irq_clr,
  input  logic [CW-1:0] thresh,
  output logic          hit_pulse,
  output logic [CW-1:0] hit_cnt,
  output logic          irq
);

  logic [CW-1:0] cnt_n;

  always_comb begin
    cnt_n = hit_cnt;
    if (clr_cnt) begin
      cnt_n = '0;
    end else if (hit && (hit_cnt != '1)) begin
      cnt_n = hit_cnt + 1'b1;
    end
  end

  // irq compares against the post-update count so set beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_pulse <= 1'b0;
      hit_cnt   <= '0;
      irq       <= 1'b0;
    end else begin
      hit_pulse <= hit;
      hit_cnt   <= cnt_n;
      if ((thresh != '0) && (cnt_n >= thresh)) begin
        irq <= 1'b1;
      end else if (irq_clr) begin
        irq <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_det_stream_ctrl.sv
// Serializes accepted stream words MSB-first into a Mealy sequence detector,
// owns the detector reset and counts its hits.
module seq_det_stream_ctrl
  import seq_det_stream_ctrl_pkg::*;
#(
  parameter int unsigned W    = DEF_W,
  parameter int unsigned CW   = DEF_CW,
  parameter logic        FILL = DEF_FILL
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  seq_det_stream_ctrl_if.slave  s,
  output logic                  det_in,
  input  logic                  det_out,
  output logic                  det_rst_n,
  input  logic [CW-1:0]         thresh,
  input  logic                  clr_cnt,
  input  logic                  irq_clr,
  output logic                  hit_pulse,
  output logic [CW-1:0]         hit_cnt,
  output logic                  irq,
  output logic                  busy
);

  localparam int unsigned     BW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0]   LAST = BW'(W - 1);

  state_t          state;
  state_t          state_n;
  logic [W-1:0]    sh;
  logic [W-1:0]    sh_n;
  logic [BW-1:0]   bcnt;
  logic [BW-1:0]   bcnt_n;
  logic            accept;
  logic            hit;

  assign accept = s.s_valid && s.s_ready;
  assign hit    = (state == ST_SHIFT) && det_out;

  always_comb begin
    state_n = state;
    sh_n    = sh;
    bcnt_n  = bcnt;
    unique case (state)
      ST_IDLE: begin
        if (en) state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (!en) begin
          state_n = ST_IDLE;
        end else if (accept) begin
          state_n = ST_SHIFT;
          sh_n    = s.s_data;
          bcnt_n  = '0;
        end
      end
      ST_SHIFT: begin
        sh_n   = {sh[W-2:0], 1'b0};
        bcnt_n = bcnt + 1'b1;
        if (!en) begin
          state_n = ST_IDLE;
        end else if (bcnt == LAST) begin
          if (accept) begin
            sh_n   = s.s_data;
            bcnt_n = '0;
          end else begin
            state_n = ST_WAIT;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with state.
  // det_rst_n drops on IDLE entry and rises one cycle after IDLE is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sh        <= '0;
      bcnt      <= '0;
      s.s_ready <= 1'b0;
      det_in    <= FILL;
      det_rst_n <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      bcnt      <= bcnt_n;
      s.s_ready <= (state_n == ST_WAIT) || ((state_n == ST_SHIFT) && (bcnt_n == LAST));
      det_in    <= (state_n == ST_SHIFT) ? sh_n[W-1] : FILL;
      det_rst_n <= (state != ST_IDLE) && (state_n != ST_IDLE);
      busy      <= (state_n == ST_SHIFT);
    end
  end

  seq_det_hit_counter #(
    .CW (CW)
  ) u_hit_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .hit       (hit),
    .clr_cnt   (clr_cnt),
    .irq_clr   (irq_clr),
    .thresh    (thresh),
    .hit_pulse (hit_pulse),
    .hit_cnt   (hit_cnt),
    .irq       (irq)
  );

endmodule

// File: tb/tb_seq_det_stream_ctrl.sv
// Bench for seq_det_stream_ctrl driving a 10010 Mealy detector, with a
// queue-based reference model of the serialized bit stream and hit counter.
module tb_seq_det_stream_ctrl;
  import seq_det_stream_ctrl_pkg::*;

  localparam int unsigned   W    = 8;
  localparam int unsigned   CW   = 3;
  localparam logic          FILL = DEF_FILL;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          clr_cnt = 1'b0;
  logic          irq_clr = 1'b0;
  logic [CW-1:0] thresh = '0;
  logic          det_in, det_out, det_rst_n, hit_pulse, irq, busy;
  logic [CW-1:0] hit_cnt;

  seq_det_stream_ctrl_if #(.W(W)) sif ();

  seq_det_stream_ctrl #(
    .W    (W),
    .CW   (CW),
    .FILL (FILL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .s         (sif),
    .det_in    (det_in),
    .det_out   (det_out),
    .det_rst_n (det_rst_n),
    .thresh    (thresh),
    .clr_cnt   (clr_cnt),
    .irq_clr   (irq_clr),
    .hit_pulse (hit_pulse),
    .hit_cnt   (hit_cnt),
    .irq       (irq),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Environment detector: Mealy 10010, overlapping, held in reset by det_rst_n
  logic [3:0] env_h;
  logic [2:0] env_len;
  always_ff @(posedge clk or negedge det_rst_n) begin
    if (!det_rst_n) begin
      env_h   <= '0;
      env_len <= '0;
    end else begin
      env_h <= {env_h[2:0], det_in};
      if (env_len < 3'd4) env_len <= env_len + 3'd1;
    end
  end
  assign det_out = det_rst_n && (env_len >= 3'd4) && ({env_h, det_in} == 5'b10010);

  // Reference model
  logic          q[$];
  logic          m_run, m_det_in, m_s_ready, m_busy, m_rst_n, m_pulse, m_irq, m_acc;
  logic [3:0]    m_h;
  int            m_hlen;
  logic [CW-1:0] m_cnt;

  int n_pass = 0, n_fail = 0, n_total = 0;
  logic [63:0] seen;
  logic        cap = 1'b0;
  int          npulse;
  logic [7:0]  feed[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; q.delete(); m_h = '0; m_hlen = 0;
    m_det_in = FILL; m_s_ready = 1'b0; m_busy = 1'b0; m_rst_n = 1'b0;
    m_cnt = '0; m_pulse = 1'b0; m_irq = 1'b0; m_acc = 1'b0;
  endtask

  function automatic logic m_hit_now();
    return m_run && (q.size() > 0) && m_rst_n && (m_hlen >= 4) &&
           ({m_h, m_det_in} == 5'b10010);
  endfunction

  task automatic model_update();
    logic hit, was_run;
    hit   = m_hit_now();
    m_acc = m_s_ready && sif.s_valid;
    if (m_rst_n) begin
      m_h = {m_h[2:0], m_det_in};
      if (m_hlen < 4) m_hlen++;
    end else begin
      m_hlen = 0;
    end
    if (clr_cnt) m_cnt = '0;
    else if (hit && (m_cnt != CMAX)) m_cnt = m_cnt + 1'b1;
    m_pulse = hit;
    if ((thresh != '0) && (m_cnt >= thresh)) m_irq = 1'b1;
    else if (irq_clr) m_irq = 1'b0;
    was_run = m_run;
    if (!m_run) begin
      m_run = en;
    end else if (!en) begin
      m_run = 1'b0;
      q.delete();
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (m_acc) for (int i = W - 1; i >= 0; i--) q.push_back(sif.s_data[i]);
    end
    m_rst_n   = was_run && m_run;
    m_busy    = m_run && (q.size() > 0);
    m_det_in  = m_busy ? q[0] : FILL;
    m_s_ready = m_run && (q.size() <= 1);
  endtask

  task automatic check_all();
    check("det_in",    det_in,      m_det_in);
    check("s_ready",   sif.s_ready, m_s_ready);
    check("busy",      busy,        m_busy);
    check("det_rst_n", det_rst_n,   m_rst_n);
    check("hit_pulse", hit_pulse,   m_pulse);
    check("hit_cnt",   hit_cnt,     m_cnt);
    check("irq",       irq,         m_irq);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_all();
    if (cap) seen = {seen[62:0], det_in};
    if (hit_pulse === 1'b1) npulse++;
  endtask

  task automatic run_feed(input int n, input logic irq_on_hit);
    for (int k = 0; k < n; k++) begin
      sif.s_valid = (feed.size() > 0);
      sif.s_data  = (feed.size() > 0) ? feed[0] : 8'h00;
      if (irq_on_hit) irq_clr = m_hit_now();
      tick();
      if (m_acc) void'(feed.pop_front());
    end
    sif.s_valid = 1'b0;
    irq_clr     = 1'b0;
  endtask

  initial begin
    logic found;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    model_reset();
    seen   = '0;
    npulse = 0;

    // Reset values
    #12;
    check("rst_det_in",    det_in,      FILL);
    check("rst_s_ready",   sif.s_ready, 0);
    check("rst_det_rst_n", det_rst_n,   0);
    check("rst_hit_cnt",   hit_cnt,     0);
    check("rst_irq",       irq,         0);
    check("rst_busy",      busy,        0);
    rst_n = 1'b1;

    // Gapless 92,49
    en = 1'b1;
    tick();
    feed = '{8'h92, 8'h49};
    cap = 1'b1; npulse = 0; seen = '0;
    run_feed(16, 1'b0);
    cap = 1'b0;
    run_feed(3, 1'b0);
    check("gapless_bits", seen[15:0], 16'h9249);
    check("gapless_hits", npulse, 4);

    // Bubble of three FILL bits between words
    cap = 1'b1; npulse = 0; seen = '0;
    feed = '{8'h90};
    run_feed(8, 1'b0);
    run_feed(3, 1'b0);
    feed = '{8'h80};
    run_feed(8, 1'b0);
    cap = 1'b0;
    run_feed(2, 1'b0);
    check("bubble_bits", seen[18:0], 19'b1001000011110000000);
    check("bubble_hits", npulse, 1);

    // Saturation and irq, with irq_clr landing on hits
    clr_cnt = 1'b1; irq_clr = 1'b1;
    tick();
    clr_cnt = 1'b0; irq_clr = 1'b0;
    thresh = 3'd3;
    feed = '{8'h92, 8'h49, 8'h92, 8'h49, 8'h92, 8'h49, 8'h92, 8'h49};
    run_feed(70, 1'b1);
    check("sat_cnt", hit_cnt, CMAX);
    check("sat_irq", irq, 1);

    // Abort at bcnt=3, then restart
    cap = 1'b1; seen = '0;
    feed = '{8'hA5};
    run_feed(4, 1'b0);
    en = 1'b0;
    run_feed(1, 1'b0);
    check("abort_det_rst_n", det_rst_n, 0);
    check("abort_s_ready", sif.s_ready, 0);
    en = 1'b1;
    run_feed(1, 1'b0);
    feed = '{8'hC3};
    run_feed(5, 1'b0);
    cap = 1'b0;
    run_feed(5, 1'b0);
    check("abort_bits", seen[10:0], 11'b10101111000);

    // clr_cnt coincident with a hit
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (feed.size() == 0) feed.push_back(8'h92);
      sif.s_valid = 1'b1;
      sif.s_data  = feed[0];
      clr_cnt     = m_hit_now();
      tick();
      if (m_acc) void'(feed.pop_front());
      if (clr_cnt) begin
        found = 1'b1;
        check("clr_hit_pulse", hit_pulse, 1);
        check("clr_hit_cnt",   hit_cnt,   0);
      end
    end
    clr_cnt = 1'b0;
    check("clr_hit_seen", found, 1);
    feed.delete();
    run_feed(10, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      en          = ($urandom_range(0, 19) != 0);
      sif.s_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       sif.s_data = 8'h92;
        1:       sif.s_data = 8'h49;
        2:       sif.s_data = 8'h90;
        default: sif.s_data = 8'($urandom);
      endcase
      clr_cnt = ($urandom_range(0, 49) == 0);
      irq_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) thresh = CW'($urandom_range(0, 7));
      tick();
    end
    clr_cnt = 1'b0; irq_clr = 1'b0; en = 1'b1;
    run_feed(2, 1'b0);

    // Asynchronous reset mid-word
    feed = '{8'hA5};
    run_feed(3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_det_in",    det_in,      FILL);
    check("arst_s_ready",   sif.s_ready, 0);
    check("arst_det_rst_n", det_rst_n,   0);
    check("arst_hit_cnt",   hit_cnt,     0);
    check("arst_irq",       irq,         0);
    check("arst_busy",      busy,        0);
    model_reset();
    #1 rst_n = 1'b1;
    feed = '{8'hC3, 8'h92};
    run_feed(24, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
